dt_peak_scan: RTL and testbench
===============================

# dt_peak_scan

Post-processing stage that runs after the distance-transform engine has filled the 128x128 result RAM. On a start pulse it streams every result byte out of the RAM in raster order and reports four figures: the largest distance value, the address where that value first occurs, the number of foreground pixels (non-zero distance), and the number of pixels at or above a programmable threshold. The block shares the result RAM read port with the DT engine and only drives it while it is busy.

## Interface

Parameters:
- THRESH, 8'd2, distance threshold used by `core_cnt` (counts pixels with value >= THRESH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle request to begin a scan; connected to DT `done`
- res_rd  out  1  result RAM read strobe
- res_addr  out  14  result RAM read address, {row[6:0], col[6:0]}
- res_di  in  8  result RAM read data, one-cycle latency
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, results valid
- max_val  out  8  largest value read
- max_addr  out  14  raster-first address of max_val
- area  out  15  count of pixels with value != 0 (range 0..16384)
- core_cnt  out  15  count of pixels with value >= THRESH

## Operation

- States: IDLE, READ, DRAIN, FIN.
- IDLE: when `start`=1, clear all accumulators, set res_addr=0, res_rd=1, busy=1, and go to READ.
- READ: res_addr increments by 1 each cycle. When res_addr=16383 has been issued, drop res_rd and go to DRAIN.
- Data pipeline:
  - A valid flag and a copy of the address are delayed one cycle behind the read strobe.
  - The datum sampled at edge n+1 belongs to the address issued at edge n.
  - Accumulate whenever the delayed valid flag is 1.
- Accumulation per sampled byte d at delayed address a:
  - if d > max_val, then max_val<=d and max_addr<=a. The comparison is strict, so ties keep the earlier raster address.
  - if d != 0, area +1.
  - if d >= THRESH, core_cnt +1.
  - Counters are 15 bits and never wrap, since at most 16384 pixels are counted.
- DRAIN: accumulate the final datum (address 16383), then go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Result outputs are held from done until the next accepted start.
- `start` is ignored while busy=1. It is accepted in FIN only on the following IDLE cycle.
- All-zero image: max_val=0, max_addr=0, area=0, core_cnt=0 (0 when THRESH>0).
- THRESH=0: core_cnt=16384.
- Reset asserted at any time, including mid-scan: immediately return to IDLE with every output at its reset value. No done pulse is produced for the aborted scan.

## Timing

- Reset values: res_rd=0, res_addr=0, busy=0, done=0, max_val=0, max_addr=0, area=0, core_cnt=0. State is IDLE.
- Edges are numbered relative to edge E, where start=1 is sampled.
- Edge E: res_rd=1, res_addr=0, busy=1.
- Edge E+k (k=0..16383): res_addr=k, res_rd=1.
- Edge E+16384: res_rd=0, res_addr holds 16383. The datum for address 16383 is present on res_di.
- Edge E+16385: last accumulation, done=1, busy=0.
- Edge E+16386: done=0.
- Start-to-done latency is 16385 cycles. Throughput is one pixel per cycle with no bubbles.
- res_rd is never high while busy=0.

## Test plan

- RAM preloaded with all zeros; pulse start. Required response:
  - res_rd high for exactly 16384 cycles.
  - done exactly 16385 cycles after start.
  - max_val=0, max_addr=0, area=0, core_cnt=0.
- RAM addr i holds (i mod 7); THRESH=2. Required response:
  - max_val=6, max_addr=6.
  - area=14043 (16384 minus the 2341 zeros).
  - core_cnt=11702.
- RAM zero except addr 100=9 and addr 9000=9 (tie); addr 16383=5. Required response:
  - max_val=9, max_addr=100.
  - area=3, core_cnt=3.
- Last-address check: only addr 16383=200. Required response: max_val=200, max_addr=16383, area=1. This confirms the DRAIN accumulation.
- Second start pulse mid-scan (cycle E+500). Required response: ignored; results identical to the single-start run.
- Reset deasserted→asserted at cycle E+8000, then released; then start a full scan. Required response:
  - All outputs are 0 during reset, and no done pulse appears for the aborted scan.
  - The rerun gives correct results, with no stale accumulator values.

Source files
------------

// File: rtl/dt_peak_scan.sv
// dt_peak_scan: raster scan of the 128x128 distance RAM reporting the peak value,
// where that peak first occurs, the foreground pixel count and the count at or above THRESH.
module dt_peak_scan #(
  parameter logic [7:0] THRESH = 8'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        busy,
  output logic        done,
  output logic [7:0]  max_val,
  output logic [13:0] max_addr,
  output logic [14:0] area,
  output logic [14:0] core_cnt
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, FIN = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        rd_q, rd_d, vld_q, vld_d;
  logic [13:0] addr_q, addr_d, paddr_q, paddr_d;
  logic [7:0]  max_val_q, max_val_d;
  logic [13:0] max_addr_q, max_addr_d;
  logic [14:0] area_q, area_d, core_q, core_d;
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    vld_d      = rd_q;
    paddr_d    = addr_q;
    max_val_d  = (vld_q && res_di > max_val_q) ? res_di : max_val_q;
    max_addr_d = (vld_q && res_di > max_val_q) ? paddr_q : max_addr_q;
    area_d     = area_q + 15'(vld_q && res_di != 8'd0);
    core_d     = core_q + 15'(vld_q && res_di >= THRESH);
    case (state_q)
      IDLE: if (start) begin
        state_d    = READ;
        rd_d       = 1'b1;
        addr_d     = '0;
        max_val_d  = '0;
        max_addr_d = '0;
        area_d     = '0;
        core_d     = '0;
      end
      READ: begin
        state_d = (addr_q == 14'h3fff) ? DRAIN : READ;
        rd_d    = (addr_q != 14'h3fff);
        addr_d  = (addr_q == 14'h3fff) ? addr_q : addr_q + 14'd1;
      end
      DRAIN:   state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      vld_q      <= 1'b0;
      paddr_q    <= '0;
      max_val_q  <= '0;
      max_addr_q <= '0;
      area_q     <= '0;
      core_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      vld_q      <= vld_d;
      paddr_q    <= paddr_d;
      max_val_q  <= max_val_d;
      max_addr_q <= max_addr_d;
      area_q     <= area_d;
      core_q     <= core_d;
    end
  end
  assign res_rd   = rd_q;
  assign res_addr = addr_q;
  assign busy     = (state_q == READ) || (state_q == DRAIN);
  assign done     = (state_q == FIN);
  assign max_val  = max_val_q;
  assign max_addr = max_addr_q;
  assign area     = area_q;
  assign core_cnt = core_q;
endmodule

// File: tb/tb_dt_peak_scan.sv
// tb_dt_peak_scan: table-driven image scans plus mid-scan restart and reset-abort sequences.
module tb_dt_peak_scan;
  logic        clk = 0, reset = 0, start = 0;
  logic        res_rd, busy, done, res_rd0, busy0, done0;
  logic [13:0] res_addr, max_addr, res_addr0, max_addr0;
  logic [7:0]  res_di, max_val, max_val0;
  logic [14:0] area, core_cnt, area0, core_cnt0;
  logic [7:0]  mem [16384];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];
  dt_peak_scan #(.THRESH(8'd2)) dut (
    .clk(clk), .reset(reset), .start(start), .res_rd(res_rd), .res_addr(res_addr),
    .res_di(res_di), .busy(busy), .done(done), .max_val(max_val), .max_addr(max_addr),
    .area(area), .core_cnt(core_cnt));
  dt_peak_scan #(.THRESH(8'd0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .res_rd(res_rd0), .res_addr(res_addr0),
    .res_di(res_di), .busy(busy0), .done(done0), .max_val(max_val0), .max_addr(max_addr0),
    .area(area0), .core_cnt(core_cnt0));
  typedef struct {
    int pat; int mid; int mv; int ma; int ar; int co;
  } vec_t;
  vec_t tbl [4];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic fill(input int p);
    for (int i = 0; i < 16384; i++)
      mem[i] = (p == 1) ? 8'(i % 7) :
               (p == 2) ? ((i == 100 || i == 9000) ? 8'd9 : (i == 16383) ? 8'd5 : 8'd0) :
               (p == 3) ? ((i == 16383) ? 8'd200 : 8'd0) : 8'd0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {res_rd, busy, done}, 0);
    chk({tag, "_addr"}, res_addr, 0);
    chk({tag, "_max_val"}, max_val, 0);
    chk({tag, "_max_addr"}, max_addr, 0);
    chk({tag, "_area"}, area, 0);
    chk({tag, "_core"}, core_cnt, 0);
  endtask
  task automatic scan(input int mid, input int abort_at);
    int cyc, rds, bad;
    bit seen;
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    chk("busy_after_start", busy, 1);
    chk("addr_after_start", res_addr, 0);
    cyc = 0; rds = res_rd; bad = 0; seen = 0;
    while (!seen && cyc < 20000) begin
      start = (cyc + 1 == mid);
      @(posedge clk); #1; cyc++;
      if (cyc == abort_at) begin
        reset = 0;
        #1 chk_zero("abort_reset");
        start = 0;
        return;
      end
      rds += int'(res_rd);
      if (res_rd && !busy) bad++;
      seen = done;
    end
    start = 0;
    chk("done_latency", cyc, 16385);
    chk("rd_cycles", rds, 16384);
    chk("rd_only_busy", bad, 0);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1 chk("done_one_cycle", done, 0);
  endtask
  initial begin
    int stray;
    tbl[0] = '{0, -1,   0,     0,     0,     0};
    tbl[1] = '{1, 500,  6,     6, 14043, 11702};
    tbl[2] = '{2, -1,   9,   100,     3,     3};
    tbl[3] = '{3, -1, 200, 16383,     1,     1};
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) reset = 1;
    @(posedge clk); #1 chk_zero("post_reset");
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        fill(1);
        scan(-1, 8000);
        stray = 0;
        repeat (3) begin
          @(posedge clk); #1 stray += int'(done);
        end
        chk_zero("held_reset");
        @(negedge clk) reset = 1;
        repeat (40) begin
          @(posedge clk); #1 stray += int'(done);
        end
        chk("no_abort_done", stray, 0);
        chk_zero("after_abort");
      end
      fill(tbl[i].pat);
      scan(tbl[i].mid, -1);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("max_val_%0d", i), max_val, tbl[i].mv);
      chk($sformatf("max_addr_%0d", i), max_addr, tbl[i].ma);
      chk($sformatf("area_%0d", i), area, tbl[i].ar);
      chk($sformatf("core_%0d", i), core_cnt, tbl[i].co);
      chk($sformatf("core_t0_%0d", i), core_cnt0, 16384);
      chk($sformatf("area_t0_%0d", i), area0, tbl[i].ar);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
